// File: rtl/skin_frame_controller_if.sv
// Result bus from the frame controller to the overlay/host logic.
// The controller drives the per-frame bounding box; the consumer drives bbox_ready.
interface skin_frame_controller_if #(
    parameter int CW = 10
);
    logic          bbox_valid;
    logic          bbox_ready;
    logic          bbox_found;
    logic [CW-1:0] bbox_x0;
    logic [CW-1:0] bbox_x1;
    logic [CW-1:0] bbox_y0;
    logic [CW-1:0] bbox_y1;
    logic [19:0]   skin_count;

    modport master (
        output bbox_valid, bbox_found, bbox_x0, bbox_x1, bbox_y0, bbox_y1, skin_count,
        input  bbox_ready
    );

    modport slave (
        input  bbox_valid, bbox_found, bbox_x0, bbox_x1, bbox_y0, bbox_y1, skin_count,
        output bbox_ready
    );
endinterface

// File: rtl/skin_frame_controller.sv
// Frame sequencer for the skin detector: forwards pixels, tracks raster position,
// accumulates the bounding box of detector hits and reports it once per frame.
module skin_frame_controller #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int MIN_COUNT = 256,
    parameter int CW        = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame_start_i,
    input  logic                           pix_valid_i,
    input  logic [15:0]                    pixel_i,
    input  logic                           det_enable_i,
    output logic                           det_valid_o,
    output logic [15:0]                    det_pixel_o,
    input  logic                           skin_i,
    skin_frame_controller_if.master        result,
    output logic                           frame_err_o,
    output logic                           busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FLUSH,
        REPORT
    } state_e;

    localparam logic [CW-1:0] X_LAST    = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] Y_LAST    = CW'(V_ACTIVE - 1);
    localparam logic [19:0]   MIN_CNT20 = 20'(MIN_COUNT);

    state_e        state_q, state_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [CW-1:0] xD_q, yD_q;
    logic          vD_q, vD_d;
    logic          enL_q, enL_d;
    logic          frameErr_q, frameErr_d;
    logic          clearAcc, loadReport;

    logic [CW-1:0] minX_q, minX_d, maxX_q, maxX_d;
    logic [CW-1:0] minY_q, minY_d, maxY_q, maxY_d;
    logic [19:0]   count_q, count_d;

    logic          bboxFound_q;
    logic [CW-1:0] bboxX0_q, bboxX1_q, bboxY0_q, bboxY1_q;
    logic [19:0]   skinCount_q;

    logic          hit;
    logic          foundNext;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        enL_d      = enL_q;
        vD_d       = 1'b0;
        frameErr_d = 1'b0;
        clearAcc   = 1'b0;
        loadReport = 1'b0;

        case (state_q)
            IDLE: begin
                if (frame_start_i) begin
                    enL_d    = det_enable_i;
                    clearAcc = 1'b1;
                    x_d      = '0;
                    y_d      = '0;
                    state_d  = ACTIVE;
                end
            end
            ACTIVE: begin
                // A restart discards the pixel presented in the same cycle.
                if (frame_start_i) begin
                    frameErr_d = 1'b1;
                    enL_d      = det_enable_i;
                    clearAcc   = 1'b1;
                    x_d        = '0;
                    y_d        = '0;
                end else if (pix_valid_i) begin
                    vD_d = 1'b1;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            state_d = FLUSH;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                loadReport = 1'b1;
                state_d    = REPORT;
                frameErr_d = frame_start_i;
            end
            REPORT: begin
                if (result.bbox_ready) begin
                    if (frame_start_i) begin
                        enL_d    = det_enable_i;
                        clearAcc = 1'b1;
                        x_d      = '0;
                        y_d      = '0;
                        state_d  = ACTIVE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    frameErr_d = frame_start_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign hit = vD_q & skin_i & enL_q;

    always_comb begin
        minX_d  = minX_q;
        maxX_d  = maxX_q;
        minY_d  = minY_q;
        maxY_d  = maxY_q;
        count_d = count_q;
        if (clearAcc) begin
            minX_d  = '1;
            minY_d  = '1;
            maxX_d  = '0;
            maxY_d  = '0;
            count_d = '0;
        end else if (hit) begin
            minX_d  = (xD_q < minX_q) ? xD_q : minX_q;
            maxX_d  = (xD_q > maxX_q) ? xD_q : maxX_q;
            minY_d  = (yD_q < minY_q) ? yD_q : minY_q;
            maxY_d  = (yD_q > maxY_q) ? yD_q : maxY_q;
            count_d = (&count_q) ? count_q : count_q + 20'd1;
        end
    end

    // The report snapshot uses next-state accumulators so the last pixel's hit is included.
    assign foundNext = enL_q & (count_d >= MIN_CNT20);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            xD_q        <= '0;
            yD_q        <= '0;
            vD_q        <= 1'b0;
            enL_q       <= 1'b0;
            frameErr_q  <= 1'b0;
            minX_q      <= '1;
            minY_q      <= '1;
            maxX_q      <= '0;
            maxY_q      <= '0;
            count_q     <= '0;
            bboxFound_q <= 1'b0;
            bboxX0_q    <= '0;
            bboxX1_q    <= '0;
            bboxY0_q    <= '0;
            bboxY1_q    <= '0;
            skinCount_q <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            xD_q       <= x_q;
            yD_q       <= y_q;
            vD_q       <= vD_d;
            enL_q      <= enL_d;
            frameErr_q <= frameErr_d;
            minX_q     <= minX_d;
            minY_q     <= minY_d;
            maxX_q     <= maxX_d;
            maxY_q     <= maxY_d;
            count_q    <= count_d;
            if (loadReport) begin
                bboxFound_q <= foundNext;
                bboxX0_q    <= foundNext ? minX_d : '0;
                bboxX1_q    <= foundNext ? maxX_d : '0;
                bboxY0_q    <= foundNext ? minY_d : '0;
                bboxY1_q    <= foundNext ? maxY_d : '0;
                skinCount_q <= count_d;
            end
        end
    end

    assign det_valid_o       = (state_q == ACTIVE) & pix_valid_i;
    assign det_pixel_o       = pixel_i;
    assign frame_err_o       = frameErr_q;
    assign busy_o            = (state_q != IDLE);
    assign result.bbox_valid = (state_q == REPORT);
    assign result.bbox_found = bboxFound_q;
    assign result.bbox_x0    = bboxX0_q;
    assign result.bbox_x1    = bboxX1_q;
    assign result.bbox_y0    = bboxY0_q;
    assign result.bbox_y1    = bboxY1_q;
    assign result.skin_count = skinCount_q;

endmodule

// File: tb/tb_skin_frame_controller.sv
// Bench for skin_frame_controller on a 4x3 frame: table vectors, corner-case
// sequences and randomized frames checked against a per-frame arithmetic model.
module tb_skin_frame_controller;

    localparam int H    = 4;
    localparam int V    = 3;
    localparam int MINC = 2;
    localparam int CW   = 3;
    localparam int NPIX = H * V;

    logic        clk = 1'b0;
    logic        rst;
    logic        frameStart, pixValid, detEnable, skinIn;
    logic        detValid, frameErr, busy;
    logic [15:0] pixel, detPixel;

    skin_frame_controller_if #(.CW(CW)) bboxIf ();

    skin_frame_controller #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .MIN_COUNT(MINC),
        .CW       (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start_i(frameStart),
        .pix_valid_i  (pixValid),
        .pixel_i      (pixel),
        .det_enable_i (detEnable),
        .det_valid_o  (detValid),
        .det_pixel_o  (detPixel),
        .skin_i       (skinIn),
        .result       (bboxIf),
        .frame_err_o  (frameErr),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    // Detector stand-in: bit 0 of a forwarded pixel marks it as skin, one cycle later.
    always @(posedge clk or posedge rst) begin
        if (rst) skinIn <= 1'b0;
        else     skinIn <= detValid & detPixel[0];
    end

    typedef struct {
        logic        en;
        logic [11:0] mask;
        logic        found;
        int          x0, x1, y0, y1, count;
    } frameVec_t;

    int checkCount = 0;
    int passCount  = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic frameVec_t modelFrame(input logic en, input logic [11:0] mask);
        frameVec_t r;
        int cnt = 0, mnx = H, mxx = -1, mny = V, mxy = -1;
        for (int i = 0; i < NPIX; i++) begin
            if (mask[i]) begin
                cnt++;
                if (i % H < mnx) mnx = i % H;
                if (i % H > mxx) mxx = i % H;
                if (i / H < mny) mny = i / H;
                if (i / H > mxy) mxy = i / H;
            end
        end
        r.en    = en;
        r.mask  = mask;
        r.found = en && (cnt >= MINC);
        r.count = en ? cnt : 0;
        r.x0    = r.found ? mnx : 0;
        r.x1    = r.found ? mxx : 0;
        r.y0    = r.found ? mny : 0;
        r.y1    = r.found ? mxy : 0;
        return r;
    endfunction

    task automatic startFrame(input logic en);
        frameStart = 1'b1;
        detEnable  = en;
        tick();
        frameStart = 1'b0;
        detEnable  = ~en;
    endtask

    task automatic applyStimulus(input logic [11:0] mask, input int n, input int maxGap);
        for (int i = 0; i < n; i++) begin
            pixValid = 1'b0;
            repeat ($urandom_range(maxGap, 0)) begin
                pixel = 16'($urandom);
                tick();
            end
            pixValid = 1'b1;
            pixel    = {15'($urandom), mask[i]};
            tick();
        end
        pixValid = 1'b0;
    endtask

    task automatic checkReport(input string tag, input frameVec_t e);
        checkOutput({tag, ".flushValid"}, int'(bboxIf.bbox_valid), 0);
        tick();
        checkOutput({tag, ".valid"}, int'(bboxIf.bbox_valid), 1);
        checkOutput({tag, ".found"}, int'(bboxIf.bbox_found), int'(e.found));
        checkOutput({tag, ".x0"},    int'(bboxIf.bbox_x0), e.x0);
        checkOutput({tag, ".x1"},    int'(bboxIf.bbox_x1), e.x1);
        checkOutput({tag, ".y0"},    int'(bboxIf.bbox_y0), e.y0);
        checkOutput({tag, ".y1"},    int'(bboxIf.bbox_y1), e.y1);
        checkOutput({tag, ".count"}, int'(bboxIf.skin_count), e.count);
    endtask

    task automatic handshake(input string tag, input int waitCycles, input logic chain, input logic chainEn);
        bboxIf.bbox_ready = 1'b0;
        repeat (waitCycles) tick();
        bboxIf.bbox_ready = 1'b1;
        frameStart        = chain;
        detEnable         = chainEn;
        tick();
        bboxIf.bbox_ready = 1'b0;
        frameStart        = 1'b0;
        detEnable         = ~chainEn;
        checkOutput({tag, ".postValid"}, int'(bboxIf.bbox_valid), 0);
        checkOutput({tag, ".postBusy"},  int'(busy), int'(chain));
        checkOutput({tag, ".postErr"},   int'(frameErr), 0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".busy"},     int'(busy), 0);
        checkOutput({tag, ".valid"},    int'(bboxIf.bbox_valid), 0);
        checkOutput({tag, ".detValid"}, int'(detValid), 0);
        checkOutput({tag, ".err"},      int'(frameErr), 0);
        checkOutput({tag, ".found"},    int'(bboxIf.bbox_found), 0);
        checkOutput({tag, ".count"},    int'(bboxIf.skin_count), 0);
        checkOutput({tag, ".x1"},       int'(bboxIf.bbox_x1), 0);
        checkOutput({tag, ".y1"},       int'(bboxIf.bbox_y1), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        frameVec_t vecs[7];
        frameVec_t e;
        logic      sawValid;
        logic      chained, curEn, nextEn;
        logic [11:0] mask;

        vecs[0] = '{en: 1'b1, mask: 12'h842, found: 1'b1, x0: 1, x1: 3, y0: 0, y1: 2, count: 3};
        vecs[1] = '{en: 1'b0, mask: 12'h842, found: 1'b0, x0: 0, x1: 0, y0: 0, y1: 0, count: 0};
        vecs[2] = '{en: 1'b1, mask: 12'h020, found: 1'b0, x0: 0, x1: 0, y0: 0, y1: 0, count: 1};
        vecs[3] = '{en: 1'b1, mask: 12'h108, found: 1'b1, x0: 0, x1: 3, y0: 0, y1: 2, count: 2};
        vecs[4] = '{en: 1'b1, mask: 12'hFFF, found: 1'b1, x0: 0, x1: 3, y0: 0, y1: 2, count: 12};
        vecs[5] = '{en: 1'b1, mask: 12'h060, found: 1'b1, x0: 1, x1: 2, y0: 1, y1: 1, count: 2};
        vecs[6] = '{en: 1'b1, mask: 12'h000, found: 1'b0, x0: 0, x1: 0, y0: 0, y1: 0, count: 0};

        rst = 1'b1; frameStart = 1'b0; pixValid = 1'b0; detEnable = 1'b0;
        pixel = 16'hA5C3; bboxIf.bbox_ready = 1'b0;
        repeat (2) tick();
        checkResetValues("reset");
        checkOutput("reset.detPixel", int'(detPixel), 16'hA5C3);
        rst = 1'b0;
        tick();

        // Table-driven frames, consumer always ready.
        for (int k = 0; k < 7; k++) begin
            bboxIf.bbox_ready = 1'b1;
            startFrame(vecs[k].en);
            applyStimulus(vecs[k].mask, NPIX, k % 2);
            checkReport($sformatf("vec%0d", k), vecs[k]);
            handshake($sformatf("vec%0d", k), 0, 1'b0, 1'b0);
        end

        // Restart after five pixels: the aborted frame must leave no trace.
        startFrame(1'b1);
        applyStimulus(12'hFFF, 5, 0);
        frameStart = 1'b1;
        detEnable  = 1'b1;
        tick();
        frameStart = 1'b0;
        checkOutput("abort.err", int'(frameErr), 1);
        checkOutput("abort.busy", int'(busy), 1);
        tick();
        checkOutput("abort.errPulse", int'(frameErr), 0);
        applyStimulus(12'h060, NPIX, 0);
        checkReport("abort", modelFrame(1'b1, 12'h060));
        handshake("abort", 0, 1'b0, 1'b0);

        // Backpressure with a dropped frame_start and stray pixels during REPORT.
        bboxIf.bbox_ready = 1'b0;
        startFrame(1'b1);
        applyStimulus(12'h842, NPIX, 1);
        e = modelFrame(1'b1, 12'h842);
        checkReport("hold", e);
        for (int c = 0; c < 10; c++) begin
            pixValid   = 1'($urandom);
            pixel      = 16'($urandom);
            frameStart = (c == 3);
            #1;
            checkOutput($sformatf("hold.detValid%0d", c), int'(detValid), 0);
            tick();
            frameStart = 1'b0;
            if (c == 3) checkOutput("hold.err", int'(frameErr), 1);
            if (c == 4) checkOutput("hold.errPulse", int'(frameErr), 0);
            checkOutput($sformatf("hold.valid%0d", c), int'(bboxIf.bbox_valid), 1);
            checkOutput($sformatf("hold.count%0d", c), int'(bboxIf.skin_count), e.count);
            checkOutput($sformatf("hold.x0_%0d", c), int'(bboxIf.bbox_x0), e.x0);
        end
        pixValid = 1'b0;
        handshake("hold", 0, 1'b0, 1'b0);
        tick();
        checkOutput("hold.idle", int'(busy), 0);

        // Reset while ACTIVE, then stray pixels must not produce a report.
        startFrame(1'b1);
        applyStimulus(12'hFFF, 3, 0);
        pixValid = 1'b1;
        #2 rst = 1'b1;
        #1 checkResetValues("rstActive");
        tick();
        rst = 1'b0;
        sawValid = 1'b0;
        for (int c = 0; c < 15; c++) begin
            pixValid = 1'($urandom);
            pixel    = 16'($urandom);
            tick();
            if (bboxIf.bbox_valid) sawValid = 1'b1;
        end
        pixValid = 1'b0;
        checkOutput("rstActive.noReport", int'(sawValid), 0);
        checkOutput("rstActive.idle", int'(busy), 0);

        // Reset while REPORT.
        startFrame(1'b1);
        applyStimulus(12'hFFF, NPIX, 0);
        checkReport("preRst", modelFrame(1'b1, 12'hFFF));
        #2 rst = 1'b1;
        #1 checkResetValues("rstReport");
        tick();
        rst = 1'b0;
        repeat (5) tick();
        checkOutput("rstReport.noReport", int'(bboxIf.bbox_valid), 0);
        bboxIf.bbox_ready = 1'b1;
        startFrame(vecs[0].en);
        applyStimulus(vecs[0].mask, NPIX, 0);
        checkReport("recover", vecs[0]);
        handshake("recover", 0, 1'b0, 1'b0);

        // Randomized frames, occasionally chained through the handshake.
        chained = 1'b0;
        curEn   = 1'b1;
        for (int f = 0; f < 25; f++) begin
            mask = 12'($urandom);
            if ($urandom_range(3, 0) == 0) mask = mask & 12'($urandom);
            if (!chained) begin
                curEn = ($urandom_range(3, 0) != 0);
                startFrame(curEn);
            end
            applyStimulus(mask, NPIX, $urandom_range(2, 0));
            checkReport($sformatf("rnd%0d", f), modelFrame(curEn, mask));
            nextEn  = ($urandom_range(3, 0) != 0);
            chained = (f < 24) && (1'($urandom));
            handshake($sformatf("rnd%0d", f), $urandom_range(3, 0), chained, nextEn);
            curEn = nextEn;
        end
        repeat (2) tick();
        checkOutput("final.idle", int'(busy), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
